ssd_scan_controller: RTL and testbench

- Time-multiplexes NUM_DIGITS hex/BCD digits onto one shared set of seven-segment lines, with one-hot digit enables.
- Contains the nibble-to-segment decode, a per-digit dwell timer and an anti-ghosting blank interval.
- Double-buffers the displayed value so updates take effect only at frame boundaries, which prevents tearing.
- Sits between the counter/datapath logic that produces values and the board's multi-digit display.

---
 rtl/ssd_scan_controller_if.sv | 23 ++
 rtl/ssd_scan_controller.sv | 169 ++++++++++++++++
 tb/tb_ssd_scan_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_controller_if.sv
// rtl/ssd_scan_controller_if.sv - value/display bus between the datapath and ssd_scan_controller
interface ssd_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    frame_done;

    modport master (
        output enable, load, value_in, dp_in,
        input  seg, dp, digit_sel, frame_done
    );

    modport slave (
        input  enable, load, value_in, dp_in,
        output seg, dp, digit_sel, frame_done
    );
endinterface

// File: rtl/ssd_scan_controller.sv
// rtl/ssd_scan_controller.sv - multiplexed seven-segment scanner with frame-synchronous double buffering
// Optional leading-zero blanking: define SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 12000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ssd_scan_controller_if.slave  bus
);
    localparam int TMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW   = 4 * NUM_DIGITS;
    localparam logic [TW-1:0] SHOW_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [VW-1:0]         shadow_q, shadow_d, active_q, active_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  fd_q, fd_d;
    logic                  boundary;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;  default: decode = 7'h71;
        endcase
    endfunction

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // Blank when this digit and every higher digit are zero; digit 0 always shows.
    function automatic logic lz_blank(input logic [VW-1:0] v, input logic [IW-1:0] i);
        logic z;
        z = (i != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(i) && v[4*k +: 4] != 4'h0) z = 1'b0;
        end
        return z;
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q + 1'b1;
        boundary    = 1'b0;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        pending_d   = pending_q;

        if (!bus.enable) begin
            state_d = IDLE;
            idx_d   = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    timer_d = '0;
                end
                BLANK: if (timer_q == BLANK_LAST) begin
                    state_d = SHOW;
                    timer_d = '0;
                end
                SHOW: if (timer_q == SHOW_LAST) begin
                    state_d = BLANK;
                    timer_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    timer_d = '0;
                end
            endcase
        end

        // Boundary takes the old shadow; a coincident load then refills shadow for the next frame.
        if (boundary && pending_q) begin
            active_d    = shadow_q;
            active_dp_d = shadow_dp_q;
            pending_d   = 1'b0;
        end
        if (bus.load) begin
            shadow_d    = bus.value_in;
            shadow_dp_d = bus.dp_in;
            if (state_q == IDLE) begin
                active_d    = bus.value_in;
                active_dp_d = bus.dp_in;
                pending_d   = 1'b0;
            end else begin
                pending_d   = 1'b1;
            end
        end

        seg_d = '0;
        dp_d  = 1'b0;
        sel_d = '0;
        fd_d  = boundary;
        if (state_d == SHOW) begin
            sel_d[idx_d] = 1'b1;
            dp_d         = active_dp_d[idx_d];
            seg_d        = decode(active_d[{idx_d, 2'b00} +: 4]);
`ifdef SSD_LEADING_ZERO_BLANK_EN
            if (lz_blank(active_d, idx_d)) seg_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            active_q    <= '0;
            active_dp_q <= '0;
            pending_q   <= 1'b0;
            seg_q       <= '0;
            dp_q        <= 1'b0;
            sel_q       <= '0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
            pending_q   <= pending_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            sel_q       <= sel_d;
            fd_q        <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.digit_sel  = sel_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb/tb_ssd_scan_controller.sv - scoreboard bench for ssd_scan_controller (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2)
module tb_ssd_scan_controller;
    localparam int N = 4;
    localparam int R = 4;
    localparam int B = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ssd_scan_controller_if #(.NUM_DIGITS(N)) bus ();

    ssd_scan_controller #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fd_last = -1;
    int n = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;
    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int idx);
        logic [6:0] s;
        s = seg_tbl[v[4*idx +: 4]];
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (idx != 0 && (v >> (4*idx)) == 16'h0) s = 7'h00;
`endif
        return s;
    endfunction

    task automatic push_slot(input logic [15:0] v, input logic [3:0] d, input int idx, input int cnt);
        logic [3:0] s;
        s = 4'b0001 << idx;
        repeat (cnt) exp_q.push_back({s, exp_seg(v, idx), d[idx]});
    endtask

    task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
        for (int i = 0; i < N; i++) push_slot(v, d, i, R);
    endtask

    task automatic wait_sel(input logic [3:0] s);
        int k = 0;
        do begin @(negedge clk); k++; end while (bus.digit_sel !== s && k < 200);
        if (bus.digit_sel !== s) begin
            total++; bad++;
            $display("FAIL wait_sel timeout: sel=%b wanted %b", bus.digit_sel, s);
        end
    endtask

    task automatic wait_fd();
        int k = 0;
        do begin @(negedge clk); k++; end while (bus.frame_done !== 1'b1 && k < 200);
        if (bus.frame_done !== 1'b1) begin
            total++; bad++;
            $display("FAIL wait_fd timeout: frame_done never pulsed");
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.load = 1'b1; bus.value_in = v; bus.dp_in = d;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Monitor: every lit cycle consumes one queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (bus.digit_sel != '0) begin
                check("onehot", $countones(bus.digit_sel), 1);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_lit: got sel=%b seg=%h dp=%b, nothing queued",
                             bus.digit_sel, bus.seg, bus.dp);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("slot {sel,seg,dp}", {bus.digit_sel, bus.seg, bus.dp}, mon_e);
                end
            end else begin
                check("dark_seg_dp", {bus.seg, bus.dp}, 0);
            end
            if (bus.frame_done) begin
                if (fd_last >= 0) check("frame_period", cyc - fd_last, N*(B+R));
                fd_last = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable = 1'b0; bus.load = 1'b0; bus.value_in = '0; bus.dp_in = '0;
        repeat (3) @(negedge clk);
        check("rst_seg", bus.seg, 0);
        check("rst_dp", bus.dp, 0);
        check("rst_sel", bus.digit_sel, 0);
        check("rst_fd", bus.frame_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_dark", bus.digit_sel, 0);

        push_frame(16'h1234, 4'b1000);
        do_load(16'h1234, 4'b1000);
        bus.enable = 1'b1;

        wait_sel(4'b0010);
        push_frame(16'hABCD, 4'b0001);
        do_load(16'hABCD, 4'b0001);

        wait_sel(4'b0001);
        push_frame(16'h5678, 4'b0000);
        do_load(16'h5678, 4'b0000);

        wait_sel(4'b1000);
        repeat (3) @(negedge clk);
        push_frame(16'h00F0, 4'b0100);
        do_load(16'h00F0, 4'b0100);
        check("fd_with_boundary_load", bus.frame_done, 1);

        wait_fd();
        push_slot(16'h00F0, 4'b0100, 0, R);
        push_slot(16'h00F0, 4'b0100, 1, R);
        push_slot(16'h00F0, 4'b0100, 2, 2);
        wait_fd();
        wait_sel(4'b0100);
        @(negedge clk);
        bus.enable = 1'b0;
        fd_last = -1;
        @(negedge clk);
        check("disable_sel", bus.digit_sel, 0);
        check("disable_seg", bus.seg, 0);

        push_frame(16'h00F0, 4'b0100);
        bus.enable = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.digit_sel == '0 && n < 20) begin n++; @(negedge clk); end
        check("reenable_blank_cycles", n, B);
        check("reenable_first_digit", bus.digit_sel, 4'b0001);

        wait_fd();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_fd", bus.frame_done, 0);
        check("async_rst_sel_fd", bus.digit_sel, 0);
        fd_last = -1;

        push_slot(16'h0000, 4'b0000, 0, R);
        push_slot(16'h0000, 4'b0000, 1, 2);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sel(4'b0010);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_seg", bus.seg, 0);
        check("async_rst_dp", bus.dp, 0);
        check("async_rst_sel", bus.digit_sel, 0);
        check("async_rst_frame_done", bus.frame_done, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
